// File: rtl/axis_vga_out_if.sv
// AXI4-Stream pixel channel feeding the VGA output stage.
// Carries one pixel per beat; tuser marks frame start, tlast marks line end.
interface axis_vga_out_if #(
    parameter int DATA_W = 32
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tuser;
    logic              tlast;

    modport master (output tvalid, tdata, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/axis_vga_out.sv
// AXI4-Stream to VGA output stage: timing generator, show-ahead pixel FIFO, SOF lock FSM.
// Latency: all VGA outputs registered one cycle after the counter state that produces them.
// Backpressure: tready = !full (1 while searching, dropping non-SOF beats); optional VGA_TEST_PATTERN_EN bars.
module axis_vga_out #(
    parameter int COLOR_W    = 8,
    parameter int DATA_W     = 32,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_POL   = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    axis_vga_out_if.slave      s_axis,
    output logic [COLOR_W-1:0] vga_r_o,
    output logic [COLOR_W-1:0] vga_g_o,
    output logic [COLOR_W-1:0] vga_b_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               vid_blank_o,
    output logic               locked_o,
    output logic               underflow_o,
    output logic               frame_start_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int PIX_W   = 3 * COLOR_W;
    localparam int ENT_W   = PIX_W + 2;
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic          SYNC_ON    = (SYNC_POL != 0);

    typedef enum logic [1:0] {ST_SEARCH, ST_WAIT_FRAME, ST_LOCKED} state_t;

    state_t             state_q, state_d;
    logic [HW-1:0]      h_cnt_q, h_cnt_d;
    logic [VW-1:0]      v_cnt_q, v_cnt_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr;
    logic [AW:0]        cnt_q, cnt_d;
    logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [COLOR_W-1:0] bg_r, bg_g, bg_b;
    logic               hsync_q, hsync_d, vsync_q, vsync_d;
    logic               blank_q, blank_d, uf_q, uf_d, fs_q, fs_d;
    logic               full, empty, accept, wr_en, pop, err, flush;
    logic               active, at_origin, at_frame_end;
    logic [ENT_W-1:0]   wr_ent, head;
    logic [DATA_W-1:0]  unused_tdata;

    assign full          = (cnt_q == FULL_CNT);
    assign empty         = (cnt_q == '0);
    assign s_axis.tready = !rst_i && ((state_q == ST_SEARCH) || !full);
    assign accept        = s_axis.tvalid && s_axis.tready;
    assign wr_ent        = {s_axis.tlast, s_axis.tuser, s_axis.tdata[PIX_W-1:0]};
    assign head          = mem_q[rd_ptr_q];
    assign unused_tdata  = s_axis.tdata;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;
    always_comb begin
        bar  = 3'((32'(h_cnt_q) * 32'd8) / H_ACTIVE);
        bg_r = {COLOR_W{bar[0]}};
        bg_g = {COLOR_W{bar[1]}};
        bg_b = {COLOR_W{bar[2]}};
    end
`else
    assign bg_r = '0;
    assign bg_g = '0;
    assign bg_b = '0;
`endif

    always_comb begin
        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
        end

        active       = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        at_origin    = (h_cnt_q == '0) && (v_cnt_q == '0);
        at_frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

        state_d = state_q;
        wr_en   = 1'b0;
        pop     = 1'b0;
        err     = 1'b0;
        flush   = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                flush = 1'b1;
                wr_en = accept && s_axis.tuser;
                if (wr_en) state_d = ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME: begin
                wr_en = accept;
                if (at_frame_end && !empty) state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                wr_en = accept;
                if (active) begin
                    if (empty) begin
                        err = 1'b1;
                    end else begin
                        pop = 1'b1;
                        // SOF must land exactly on (0,0); EOL only on the last active column.
                        err = (head[PIX_W] != at_origin) ||
                              (head[PIX_W+1] && (h_cnt_q != H_ACT_LAST));
                    end
                end
                if (err) begin
                    flush   = 1'b1;
                    wr_en   = 1'b0;
                    state_d = ST_SEARCH;
                end
            end
            default: state_d = ST_SEARCH;
        endcase

        // A flush restarts the FIFO at slot 0, so a SOF beat taken while searching lands there.
        wr_addr = flush ? '0 : wr_ptr_q;
        if (flush) begin
            wr_ptr_d = wr_en ? AW'(1) : '0;
            rd_ptr_d = '0;
            cnt_d    = wr_en ? CNT_ONE : '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(wr_en);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            cnt_d    = cnt_q + (AW + 1)'(wr_en) - (AW + 1)'(pop);
        end

        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (active) begin
            if (state_q == ST_LOCKED) begin
                if (!err) {b_d, g_d, r_d} = head[PIX_W-1:0];
            end else begin
                r_d = bg_r;
                g_d = bg_g;
                b_d = bg_b;
            end
        end
        hsync_d = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? SYNC_ON : !SYNC_ON;
        vsync_d = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? SYNC_ON : !SYNC_ON;
        blank_d = active;
        uf_d    = err;
        fs_d    = (state_q == ST_LOCKED) && active && at_origin && !err;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_SEARCH;
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            hsync_q  <= !SYNC_ON;
            vsync_q  <= !SYNC_ON;
            blank_q  <= 1'b0;
            uf_q     <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            blank_q  <= blank_d;
            uf_q     <= uf_d;
            fs_q     <= fs_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_addr] <= wr_ent;
    end

    assign vga_r_o       = r_q;
    assign vga_g_o       = g_q;
    assign vga_b_o       = b_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign vid_blank_o   = blank_q;
    assign locked_o      = (state_q == ST_LOCKED);
    assign underflow_o   = uf_q;
    assign frame_start_o = fs_q;
endmodule

// File: tb/tb_axis_vga_out.sv
// Directed bench for axis_vga_out on a tiny 8x4 raster (H_TOTAL 14, V_TOTAL 7, FIFO depth 4).
module tb_axis_vga_out;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_vga_out_if #(.DATA_W(32)) s_if ();

    logic [7:0] r, g, b;
    logic       hs, vs, blank, locked, uf, fs;

    axis_vga_out #(
        .COLOR_W(8), .DATA_W(32),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(0), .FIFO_DEPTH(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .s_axis(s_if),
        .vga_r_o(r), .vga_g_o(g), .vga_b_o(b),
        .hsync_o(hs), .vsync_o(vs), .vid_blank_o(blank),
        .locked_o(locked), .underflow_o(uf), .frame_start_o(fs)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Stream source: 32-pixel frames, value p+1, tuser on p==0, tlast every 8th pixel.
    int p = 0;
    bit src_en = 1'b0;
    int bad_phase = 0;

    int hs_lo, vs_lo, bl_hi, first_hs, n_uf, got;
    bit found, uf_lock, uf_rdy;
    logic [23:0] row0 [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        s_if.tvalid = src_en;
        s_if.tdata  = 32'(p + 1);
        s_if.tuser  = (p == 0) || (bad_phase == 2 && p == 3);
        s_if.tlast  = (p % 8 == 7);
    endtask

    task automatic tick();
        bit acc;
        @(negedge clk);
        acc = s_if.tvalid && s_if.tready;
        @(posedge clk);
        #1;
        if (acc) begin
            if (bad_phase == 2 && p == 3) bad_phase = 0;
            p = (p + 1) % 32;
            if (bad_phase == 1 && p == 16) bad_phase = 2;
        end
        drive();
    endtask

    initial begin
`ifdef VGA_TEST_PATTERN_EN
        row0 = '{24'h000000, 24'hFF0000, 24'h00FF00, 24'hFFFF00,
                 24'h0000FF, 24'hFF00FF, 24'h00FFFF, 24'hFFFFFF};
`else
        row0 = '{default: 24'h000000};
`endif
        drive();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_rgb", {r, g, b}, 0);
        chk("rst_blank", blank, 0);
        chk("rst_locked", locked, 0);
        chk("rst_uf", uf, 0);
        chk("rst_fs", fs, 0);
        chk("rst_hsync", hs, 1);
        chk("rst_vsync", vs, 1);
        chk("rst_tready", s_if.tready, 0);
        rst = 1'b0;

        // Free-running raster, no stream: one full frame of outputs.
        hs_lo = 0; vs_lo = 0; bl_hi = 0; first_hs = -1; n_uf = 0;
        for (int k = 1; k <= 98; k++) begin
            tick();
            if (!hs) begin
                hs_lo++;
                if (first_hs < 0) first_hs = k;
            end
            if (!vs) vs_lo++;
            if (blank) bl_hi++;
            if (uf) n_uf++;
            if (k <= 8) chk("row0_rgb", {r, g, b}, row0[k-1]);
        end
        chk("hsync_low_cycles", hs_lo, 14);
        chk("hsync_first_low", first_hs, 11);
        chk("vsync_low_cycles", vs_lo, 14);
        chk("blank_high_cycles", bl_hi, 32);
        chk("freerun_locked", locked, 0);
        chk("freerun_uf", n_uf, 0);

        // Continuous stream: lock, then raster shows 1..32.
        src_en = 1'b1;
        drive();
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            tick();
            found = fs;
        end
        chk("lock_fs_seen", found, 1);
        chk("fs_value", r, 1);
        chk("fs_gb", {g, b}, 0);
        chk("fs_locked", locked, 1);
        got = 1; n_uf = 0;
        for (int k = 0; k < 200 && got < 32; k++) begin
            tick();
            if (uf) n_uf++;
            if (blank) begin
                got++;
                chk("raster_r", r, got);
            end
        end
        chk("raster_count", got, 32);
        chk("stream_uf", n_uf, 0);

        // Stall the stream mid-frame.
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            tick();
            found = fs;
        end
        chk("fs2_seen", found, 1);
        tick(); tick(); tick();
        src_en = 1'b0;
        drive();
        n_uf = 0; uf_lock = 1'b1; uf_rdy = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (uf) begin
                n_uf++;
                uf_lock = locked;
                uf_rdy  = s_if.tready;
            end
        end
        src_en = 1'b1;
        drive();
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            tick();
            if (uf) n_uf++;
            found = fs;
        end
        chk("stall_uf_count", n_uf, 1);
        chk("stall_locked_drop", uf_lock, 0);
        chk("stall_tready", uf_rdy, 1);
        chk("relock_seen", found, 1);
        chk("relock_value", r, 1);
        chk("relock_locked", locked, 1);

        // Misaligned SOF on pixel 3 of the next frame.
        bad_phase = 1;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            tick();
            found = uf;
        end
        chk("misalign_seen", found, 1);
        chk("misalign_locked", locked, 0);
        chk("misalign_tready", s_if.tready, 1);
        chk("misalign_black", {r, g, b}, 0);
        chk("misalign_blank", blank, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("search_tready", s_if.tready, 1);
            chk("search_locked", locked, 0);
        end

        // One-cycle reset mid-line.
        src_en = 1'b0;
        drive();
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            tick();
            found = blank;
        end
        chk("midline_found", found, 1);
        rst = 1'b1;
        tick();
        chk("rst2_rgb", {r, g, b}, 0);
        chk("rst2_blank", blank, 0);
        chk("rst2_locked", locked, 0);
        chk("rst2_uf", uf, 0);
        chk("rst2_fs", fs, 0);
        chk("rst2_hsync", hs, 1);
        chk("rst2_vsync", vs, 1);
        chk("rst2_tready", s_if.tready, 0);
        rst = 1'b0;
        for (int k = 1; k <= 71; k++) begin
            tick();
            if (k == 1)  chk("restart_blank_h0", blank, 1);
            if (k == 10) chk("restart_hsync_h9", hs, 1);
            if (k == 11) chk("restart_hsync_h10", hs, 0);
            if (k == 70) chk("restart_vsync_v4", vs, 1);
            if (k == 71) chk("restart_vsync_v5", vs, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
